// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and transmitter state encoding.
package uart_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Core memory-port view of the UART: store/load strobes and address/data in, decode hit and read data out.
interface uart_tx_mmio_if;
  logic        memwrite;
  logic        memread;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        hit;
  logic [31:0] rdata;

  modport master (output memwrite, memread, adr, writedata, input hit, rdata);
  modport slave  (input memwrite, memread, adr, writedata, output hit, rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; data is poppable the cycle after the push edge.
// Pushes while full and pops while empty are ignored, so the caller owns overflow reporting.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA enqueue a byte, STATUS reports FIFO/FSM state.
// txd falls one clk after the enqueuing store; stores while the FIFO is full are dropped and flag overflow.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_mmio_if.slave bus,
  output logic          txd,
  output logic          tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] DIV_M1 = BW'(CLK_DIV - 1);

  logic          hit;
  logic          sel_txdata;
  logic          sel_status;
  logic          push_req;
  logic          ovf_set;
  logic          ovf_clr;
  logic          ovf_q;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word;

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  // Memread only qualifies the core's own read mux; decode never depends on it.
  logic unused_inputs;
  assign unused_inputs = ^{bus.memread, bus.writedata[31:8]};

  assign hit        = (bus.adr[31:3] == BASE_ADDR[31:3]) && (bus.adr[1:0] == 2'b00);
  assign sel_txdata = hit && (bus.adr[2] == TXDATA_OFS[2]);
  assign sel_status = hit && (bus.adr[2] == STATUS_OFS[2]);

  assign push_req = bus.memwrite & sel_txdata;
  assign ovf_set  = push_req & fifo_full;
  assign ovf_clr  = bus.memwrite & sel_status & bus.writedata[STAT_OVF];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_req),
    .push_dat (bus.writedata[7:0]),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    status_word                                = '0;
    status_word[STAT_FULL]                     = fifo_full;
    status_word[STAT_EMPTY]                    = fifo_empty;
    status_word[STAT_BUSY]                     = (state_q != IDLE);
    status_word[STAT_OVF]                      = ovf_q;
    status_word[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
  end

  assign bus.hit   = hit;
  assign bus.rdata = sel_status ? status_word : 32'h0;
  assign txd       = txd_q;
  assign tx_busy   = ~fifo_empty | (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          baud_d   = DIV_M1;
          state_d  = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = DIV_M1;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d  = DIV_M1;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          state_d = IDLE;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // txd is registered from the next state so the line changes on the same edge as the state.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=4, BASE_ADDR=0x400.
module tb_uart_tx_mmio;

  logic clk = 1'b0;
  logic reset;
  logic txd;
  logic tx_busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int cyc    = 0;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .BASE_ADDR  (32'h0000_0400),
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .txd     (txd),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.adr       = a;
    bus.writedata = d;
    tick();
    bus.memwrite  = 1'b0;
  endtask

  task automatic rd_status(output logic [31:0] v);
    bus.adr     = 32'h0000_0404;
    bus.memread = 1'b1;
    #1;
    v           = bus.rdata;
    bus.memread = 1'b0;
  endtask

  // Called on the cycle the start bit begins; returns at start+38 (mid stop bit).
  task automatic rx_byte(input string tag, output logic [7:0] b);
    b = '0;
    tick(2);
    check({tag, "_start"}, {31'b0, txd}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick(4);
      b[i] = txd;
    end
    tick(4);
    check({tag, "_stop"}, {31'b0, txd}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] st;
    logic [7:0]  rb;
    logic [9:0]  seq;
    logic [7:0]  exp_bytes [4];
    int          bad;
    int          e2;

    reset         = 1'b1;
    bus.memwrite  = 1'b0;
    bus.memread   = 1'b0;
    bus.adr       = '0;
    bus.writedata = '0;
    tick(3);
    reset = 1'b0;

    // Reset state and 50 idle cycles.
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (txd !== 1'b1) bad++;
    end
    check("idle_txd_glitches", bad, 0);
    check("reset_txd", {31'b0, txd}, 32'h1);
    check("reset_busy", {31'b0, tx_busy}, 32'h0);
    rd_status(st);
    check("reset_status", st, 32'h2);
    check("status_hit", {31'b0, bus.hit}, 32'h1);
    bus.adr = 32'h0000_0400;
    bus.memread = 1'b1;
    #1;
    check("txdata_hit", {31'b0, bus.hit}, 32'h1);
    check("txdata_read_zero", bus.rdata, 32'h0);
    bus.memread = 1'b0;

    // Single byte 0x55: exact bit timing and busy window.
    store(32'h400, 32'h55);
    check("p55_txd_push_cycle", {31'b0, txd}, 32'h1);
    check("p55_busy_push_cycle", {31'b0, tx_busy}, 32'h1);
    tick();
    seq = 10'b1010101010;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("p55_bit%0d", k), {31'b0, txd}, {31'b0, seq[k]});
      if (k < 9) tick(4);
      else tick(3);
    end
    check("p55_busy_last", {31'b0, tx_busy}, 32'h1);
    tick();
    check("p55_busy_clear", {31'b0, tx_busy}, 32'h0);
    check("p55_txd_idle", {31'b0, txd}, 32'h1);
    tick(5);

    // Back-to-back 0x41, 0x42: one idle cycle between frames.
    store(32'h400, 32'h41);
    store(32'h400, 32'h42);
    check("b2b_first_start", {31'b0, txd}, 32'h0);
    rx_byte("b2b_f1", rb);
    check("b2b_byte1", {24'b0, rb}, 32'h41);
    tick(2);
    check("b2b_gap_txd", {31'b0, txd}, 32'h1);
    rd_status(st);
    check("b2b_gap_status", st, 32'h10);
    tick();
    check("b2b_second_start", {31'b0, txd}, 32'h0);
    rx_byte("b2b_f2", rb);
    check("b2b_byte2", {24'b0, rb}, 32'h42);
    tick(3);
    check("b2b_busy_clear", {31'b0, tx_busy}, 32'h0);
    tick(5);

    // Six consecutive stores into a 4-deep FIFO: 6th is dropped.
    store(32'h400, 32'h11);
    store(32'h400, 32'h22);
    e2 = cyc;
    store(32'h400, 32'h33);
    store(32'h400, 32'h44);
    store(32'h400, 32'h55);
    store(32'h400, 32'h66);
    rd_status(st);
    check("ovf_status_set", st, 32'h4D);
    store(32'h404, 32'h8);
    rd_status(st);
    check("ovf_status_cleared", st, 32'h45);
    store(32'h400, 32'h99);
    rd_status(st);
    check("ovf_status_reset", st, 32'h4D);
    store(32'h404, 32'hFFFF_FFF7);
    rd_status(st);
    check("ovf_clear_needs_bit3", st, 32'h4D);
    store(32'h404, 32'h8);
    rd_status(st);
    check("ovf_status_cleared2", st, 32'h45);
    exp_bytes[0] = 8'h22;
    exp_bytes[1] = 8'h33;
    exp_bytes[2] = 8'h44;
    exp_bytes[3] = 8'h55;
    tick(e2 + 41 - cyc);
    for (int f = 0; f < 4; f++) begin
      check($sformatf("ovf_f%0d_start", f + 2), {31'b0, txd}, 32'h0);
      rx_byte($sformatf("ovf_f%0d", f + 2), rb);
      check($sformatf("ovf_f%0d_byte", f + 2), {24'b0, rb}, {24'b0, exp_bytes[f]});
      if (f < 3) tick(3);
    end
    tick();
    check("ovf_busy_last", {31'b0, tx_busy}, 32'h1);
    tick();
    check("ovf_busy_clear", {31'b0, tx_busy}, 32'h0);
    rd_status(st);
    check("ovf_final_status", st, 32'h2);
    tick(5);

    // Decode misses.
    bus.adr = 32'h0000_0408;
    bus.memread = 1'b1;
    #1;
    check("miss_408_hit", {31'b0, bus.hit}, 32'h0);
    check("miss_408_rdata", bus.rdata, 32'h0);
    bus.memread   = 1'b0;
    bus.adr       = 32'h0000_0402;
    bus.writedata = 32'h77;
    bus.memwrite  = 1'b1;
    #1;
    check("misalign_hit", {31'b0, bus.hit}, 32'h0);
    tick();
    bus.memwrite = 1'b0;
    tick();
    check("misalign_txd", {31'b0, txd}, 32'h1);
    check("misalign_busy", {31'b0, tx_busy}, 32'h0);
    rd_status(st);
    check("misalign_status", st, 32'h2);

    // Reset during data bit 3 aborts the frame and flushes the queued byte.
    store(32'h400, 32'hF0);
    store(32'h400, 32'h0F);
    tick(17);
    check("rst_bit3_txd", {31'b0, txd}, 32'h0);
    reset = 1'b1;
    tick();
    check("rst_txd", {31'b0, txd}, 32'h1);
    check("rst_busy", {31'b0, tx_busy}, 32'h0);
    rd_status(st);
    check("rst_status", st, 32'h2);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("rst_no_more_frames", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
